// File: rtl/ym3438_pkg.sv
// Shared widths and channel-3 mode encodings for the OPN2 timer stage.
package ym3438_pkg;

    localparam int TA_W     = 10;
    localparam int TB_W     = 8;
    localparam int TB_PRE_W = 4;

    localparam logic [1:0] CH3_MODE_NORMAL  = 2'b00;
    localparam logic [1:0] CH3_MODE_SPECIAL = 2'b01;
    localparam logic [1:0] CH3_MODE_CSM     = 2'b10;

    function automatic logic is_csm(input logic [1:0] mode);
        return mode == CH3_MODE_CSM;
    endfunction

endpackage

// File: rtl/ym3438_timers_if.sv
// Register-side and status-side signals of the timer stage.
interface ym3438_timers_if;
    import ym3438_pkg::*;

    logic            c1;
    logic            timer_ed;
    logic [TA_W-1:0] timer_a_reg;
    logic [TB_W-1:0] timer_b_reg;
    logic            load_a;
    logic            load_b;
    logic            enable_a;
    logic            enable_b;
    logic            reset_a;
    logic            reset_b;
    logic [1:0]      ch3_mode;
    logic            timer_a;
    logic            timer_b;
    logic            ovf_a;
    logic            ovf_b;
    logic            csm_kon;

    modport master (
        output c1, timer_ed, timer_a_reg, timer_b_reg, load_a, load_b,
               enable_a, enable_b, reset_a, reset_b, ch3_mode,
        input  timer_a, timer_b, ovf_a, ovf_b, csm_kon
    );

    modport slave (
        input  c1, timer_ed, timer_a_reg, timer_b_reg, load_a, load_b,
               enable_a, enable_b, reset_a, reset_b, ch3_mode,
        output timer_a, timer_b, ovf_a, ovf_b, csm_kon
    );

endinterface

// File: rtl/ym3438_timer_cnt.sv
// Up-counter with reload: holds the reload value while load=0 and reloads on
// wrap. 'tick' qualifies the hold-reload, 'step' qualifies counting.
module ym3438_timer_cnt #(
    parameter int W = 10
) (
    input  logic         MCLK,
    input  logic         IC,
    input  logic         tick,
    input  logic         step,
    input  logic         load,
    input  logic [W-1:0] reload,
    output logic         ovf
);

    logic [W-1:0] cnt;

    assign ovf = step & load & (cnt == '1);

    always_ff @(posedge MCLK or negedge IC) begin
        if (!IC) begin
            cnt <= '0;
        end else if (tick) begin
            if (!load || ovf) begin
                cnt <= reload;
            end else if (step) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ym3438_timers.sv
// Timer A / Timer B stage: counters, Timer B sample prescaler, status flags,
// registered overflow pulses and the CSM key-on pulse.
module ym3438_timers
    import ym3438_pkg::*;
(
    input  logic           MCLK,
    input  logic           IC,
    ym3438_timers_if.slave bus
);

    logic                tick;
    logic                tick_b;
    logic                ovf_a_w;
    logic                ovf_b_w;
    logic [TB_PRE_W-1:0] pre_b;
    logic                flag_a;
    logic                flag_b;
    logic                ovf_a_q;
    logic                ovf_b_q;
    logic                csm_q;

    assign tick   = bus.c1 & bus.timer_ed;
    assign tick_b = tick & (&pre_b);

    ym3438_timer_cnt #(.W(TA_W)) u_cnt_a (
        .MCLK   (MCLK),
        .IC     (IC),
        .tick   (tick),
        .step   (tick),
        .load   (bus.load_a),
        .reload (bus.timer_a_reg),
        .ovf    (ovf_a_w)
    );

    // B keeps its reload value on every sample tick but only counts once per 16
    ym3438_timer_cnt #(.W(TB_W)) u_cnt_b (
        .MCLK   (MCLK),
        .IC     (IC),
        .tick   (tick),
        .step   (tick_b),
        .load   (bus.load_b),
        .reload (bus.timer_b_reg),
        .ovf    (ovf_b_w)
    );

    always_ff @(posedge MCLK or negedge IC) begin
        if (!IC) begin
            pre_b   <= '0;
            flag_a  <= 1'b0;
            flag_b  <= 1'b0;
            ovf_a_q <= 1'b0;
            ovf_b_q <= 1'b0;
            csm_q   <= 1'b0;
        end else if (bus.c1) begin
            if (tick) begin
                pre_b <= pre_b + 1'b1;
            end
            // set wins over clear so an overflow is never dropped
            flag_a  <= (ovf_a_w & bus.enable_a) | (flag_a & ~bus.reset_a);
            flag_b  <= (ovf_b_w & bus.enable_b) | (flag_b & ~bus.reset_b);
            ovf_a_q <= ovf_a_w;
            ovf_b_q <= ovf_b_w;
            csm_q   <= ovf_a_w & is_csm(bus.ch3_mode);
        end
    end

    assign bus.timer_a = flag_a;
    assign bus.timer_b = flag_b;
    assign bus.ovf_a   = ovf_a_q;
    assign bus.ovf_b   = ovf_b_q;
    assign bus.csm_kon = csm_q;

endmodule

// File: tb/tb_ym3438_timers.sv
// Directed bench for the timer stage: counts, prescaler phase, flags, CSM, reset.
module tb_ym3438_timers;
    import ym3438_pkg::*;

    logic MCLK;
    logic IC;
    int   checks;
    int   failures;
    int   ovf_seen;

    ym3438_timers_if bus ();

    ym3438_timers dut (
        .MCLK (MCLK),
        .IC   (IC),
        .bus  (bus.slave)
    );

    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // one c1 period: a c1 edge (tick if ed=1) followed by a c1=0 edge with timer_ed high
    task automatic cyc(input logic ed);
        bus.c1       = 1'b1;
        bus.timer_ed = ed;
        @(posedge MCLK);
        #1;
        bus.c1       = 1'b0;
        bus.timer_ed = 1'b1;
        @(posedge MCLK);
        #1;
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        IC          = 1'b0;
        bus.c1      = 1'b0;
        bus.timer_ed = 1'b0;
        bus.timer_a_reg = 10'd1020;
        bus.timer_b_reg = 8'd254;
        bus.load_a  = 1'b0;
        bus.load_b  = 1'b0;
        bus.enable_a = 1'b1;
        bus.enable_b = 1'b1;
        bus.reset_a = 1'b0;
        bus.reset_b = 1'b0;
        bus.ch3_mode = CH3_MODE_NORMAL;

        repeat (3) @(posedge MCLK);
        #1;
        check("rst_timer_a", bus.timer_a, 0);
        check("rst_timer_b", bus.timer_b, 0);
        check("rst_ovf_a",   bus.ovf_a,   0);
        check("rst_ovf_b",   bus.ovf_b,   0);
        check("rst_csm_kon", bus.csm_kon, 0);
        IC = 1'b1;

        // Timer A from 1020: overflow on every 4th counting tick
        cyc(1);
        check("a_hold_ovf", bus.ovf_a, 0);
        bus.load_a = 1'b1;
        cyc(1); cyc(1); cyc(1);
        check("a_pre_ovf", bus.ovf_a, 0);
        check("a_pre_flag", bus.timer_a, 0);
        cyc(1);
        check("a_ovf1", bus.ovf_a, 1);
        check("a_flag1", bus.timer_a, 1);
        cyc(0);
        check("a_ovf_pulse_end", bus.ovf_a, 0);
        check("a_flag_hold", bus.timer_a, 1);
        cyc(1); cyc(1); cyc(1);
        check("a_mid_ovf", bus.ovf_a, 0);
        cyc(1);
        check("a_ovf2", bus.ovf_a, 1);

        // async reset mid-pulse; ticks during reset are lost
        IC = 1'b0;
        #1;
        check("ic_async_ovf_a", bus.ovf_a, 0);
        check("ic_async_timer_a", bus.timer_a, 0);
        bus.load_a = 1'b0;
        cyc(1); cyc(1);
        check("ic_held_timer_a", bus.timer_a, 0);
        check("ic_held_ovf_a", bus.ovf_a, 0);
        IC = 1'b1;

        // tick 1 after release loads both counters; then A period 4, B period 32
        bus.ch3_mode = CH3_MODE_CSM;
        cyc(1);
        check("rel_t1_ovf_a", bus.ovf_a, 0);
        bus.load_a = 1'b1;
        bus.load_b = 1'b1;
        for (int t = 2; t <= 64; t++) begin
            if (t == 33) bus.ch3_mode = CH3_MODE_SPECIAL;
            cyc(1);
            check($sformatf("t%0d_ovf_a", t), bus.ovf_a, (t >= 5 && (t - 1) % 4 == 0) ? 1 : 0);
            check($sformatf("t%0d_ovf_b", t), bus.ovf_b, (t == 32 || t == 64) ? 1 : 0);
            check($sformatf("t%0d_timer_b", t), bus.timer_b, (t >= 32) ? 1 : 0);
            check($sformatf("t%0d_csm_kon", t), bus.csm_kon,
                  (t <= 32 && t >= 5 && (t - 1) % 4 == 0) ? 1 : 0);
        end

        // flag clears, c1-qualified; B unaffected by reset_a
        bus.reset_a = 1'b1;
        cyc(0);
        bus.reset_a = 1'b0;
        check("clr_timer_a", bus.timer_a, 0);
        check("clr_a_keeps_b", bus.timer_b, 1);
        bus.reset_b = 1'b1;
        cyc(0);
        bus.reset_b = 1'b0;
        check("clr_timer_b", bus.timer_b, 0);

        // tick 65 overflows A while reset_a is strobed: set wins
        bus.reset_a = 1'b1;
        cyc(1);
        bus.reset_a = 1'b0;
        check("coinc_ovf_a", bus.ovf_a, 1);
        check("coinc_timer_a", bus.timer_a, 1);

        // enable gating with reload 1023 (takes effect at next reload)
        bus.reset_a = 1'b1;
        cyc(0);
        bus.reset_a = 1'b0;
        check("gate_clr", bus.timer_a, 0);
        bus.enable_a = 1'b0;
        bus.timer_a_reg = 10'd1023;
        cyc(1); cyc(1); cyc(1);
        check("gate_old_period", bus.ovf_a, 0);
        cyc(1);
        check("gate_ovf0", bus.ovf_a, 1);
        check("gate_flag0", bus.timer_a, 0);
        cyc(1);
        check("gate_ovf1", bus.ovf_a, 1);
        check("gate_flag1", bus.timer_a, 0);
        cyc(1);
        check("gate_ovf2", bus.ovf_a, 1);
        bus.enable_a = 1'b1;
        cyc(1);
        check("gate_en_flag", bus.timer_a, 1);
        bus.enable_a = 1'b0;
        cyc(1);
        check("gate_dis_keeps_flag", bus.timer_a, 1);

        // load_a=0 holds the counter: no overflow for 100 ticks
        bus.load_a = 1'b0;
        cyc(1);
        ovf_seen = 0;
        for (int i = 0; i < 100; i++) begin
            cyc(1);
            if (bus.ovf_a === 1'b1) ovf_seen++;
        end
        check("hold_no_ovf", ovf_seen, 0);
        bus.load_a = 1'b1;
        cyc(1);
        check("hold_release_ovf", bus.ovf_a, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ym3438_timers.md
Name: ym3438_timers

Overview:
- Timer A / Timer B stage of the OPN2 core; sits between the register controller and the io block.
- Consumes the timer registers (0x24–0x27) and the fsm per-sample tick.
- Produces the timer_a/timer_b status flags that ym3438_io reads back and uses for IRQ.
- Produces the CSM key-on pulse for channel 3.

Parameters:
- TA_W, 10, Timer A counter/register width
- TB_W, 8, Timer B counter/register width
- TB_PRE_W, 4, Timer B sample prescaler width (divide by 16)

Ports:
- MCLK  in  1  master clock; all state on rising edge
- IC  in  1  asynchronous active-low reset (initial clear)
- c1  in  1  phase enable from prescaler; state updates only on MCLK edges with c1=1
- timer_ed  in  1  per-sample tick from fsm; counted only when c1=1 (tick = c1 & timer_ed)
- timer_a_reg  in  10  Timer A reload value (0x24/0x25)
- timer_b_reg  in  8  Timer B reload value (0x26)
- load_a, load_b  in  1 each  run bits (0x27 bits 0,1), level
- enable_a, enable_b  in  1 each  flag-set enables (0x27 bits 2,3), level
- reset_a, reset_b  in  1 each  flag-clear strobes (0x27 bits 4,5 write), qualified by c1
- ch3_mode  in  2  0x27 bits 7:6
- timer_a  out  1  Timer A status flag
- timer_b  out  1  Timer B status flag
- ovf_a  out  1  Timer A overflow pulse
- ovf_b  out  1  Timer B overflow pulse
- csm_kon  out  1  CSM key-on pulse for channel 3 operators

Behaviour:
- Reset (IC=0, async): all counters, prescaler, flags and pulse outputs go to 0 immediately and stay 0 while IC=0.
- All outputs are registered. Outputs change only on c1-enabled edges and hold between them.
- Timer A, on each tick:
  - load_a=0: cnt_a <= timer_a_reg (held at reload value; starts counting from it when load_a rises).
  - load_a=1 and cnt_a==1023: overflow; cnt_a <= timer_a_reg.
  - load_a=1 otherwise: cnt_a <= cnt_a+1 (10-bit).
  - Period = 1024−N ticks; N=1023 overflows every tick.
- Timer B prescaler:
  - pre_b is 4-bit, increments on every tick regardless of load_b, and wraps 15->0.
  - pre_b is cleared only by IC.
- Timer B counter: advances only on ticks where pre_b==15, with the same hold/overflow/reload rules as A at 255. Period = (256−N)×16 ticks, phase-locked to pre_b.
- ovf_a / ovf_b: 1 for exactly one c1 period following the overflowing tick, else 0.
- Flags (timer_a, timer_b):
  - set on overflow when the matching enable_x=1;
  - cleared by a c1-qualified reset_x;
  - a set and a clear on the same c1 edge leaves the flag 1 (overflow never lost);
  - enable_x=0 does not clear an already-set flag;
  - a reload value change takes effect at the next reload or while load=0.
- csm_kon = ovf_a & (ch3_mode==2'b10). It is one c1 period wide and independent of enable_a.
- timer_ed without c1 is ignored. Ticks arriving while IC=0 are lost.

Decomposition:
- Shared package ym3438_pkg:
  - TA_W, TB_W, TB_PRE_W;
  - CH3_MODE_NORMAL=2'b00, CH3_MODE_SPECIAL=2'b01, CH3_MODE_CSM=2'b10.
- Sub-module ym3438_timer_cnt (parameter W):
  - inputs: tick enable, load, reload value;
  - outputs: overflow;
  - instantiated for A (W=10) and B (W=8, tick gated by pre_b==15).
- Flags, prescaler and csm_kon live in the top.

Test Plan:
- Timer A count: timer_a_reg=1020, load_a=1, enable_a=1, ticks every 24 c1.
  - ovf_a after the 4th tick; timer_a=1; cnt_a=1020; repeats every 4 ticks.
- Timer B count: after IC release, timer_b_reg=254, load_b=1, enable_b=1.
  - First B advance at tick 16; ovf_b and timer_b=1 at tick 32; next at tick 64.
- Enable gating: enable_a=0, timer_a_reg=1023, load_a=1.
  - ovf_a pulses every tick; timer_a stays 0.
  - Then enable_a=1 -> flag set on the next tick.
- Flag clear:
  - flag set, reset_a strobe with no overflow -> timer_a=0 next c1;
  - reset_a coincident with an overflow (enable_a=1) -> timer_a stays 1.
- CSM: ch3_mode=2'b10, Timer A overflows -> csm_kon=1 for exactly one c1 period; ch3_mode=2'b01 -> csm_kon stays 0.
- Reset and hold:
  - IC low mid-count with timer_a=1 -> all outputs 0 asynchronously; after release cnt_a restarts from timer_a_reg.
  - load_a=0 for 100 ticks -> no ovf_a.
